// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : instruction prefetch FIFO of {PC, instruction} feeding the IF
// stage; optional same-cycle bypass when FETCH_QUEUE_BYPASS_EN is defined.
// Revision 1.0
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic                         Clock,
  input  logic                         nReset,
  input  logic [31:0]                  PC_in,
  input  logic [31:0]                  instruction_in,
  input  logic                         valid_in,
  output logic                         ready_out,
  output logic [31:0]                  PC_out,
  output logic [31:0]                  instruction_out,
  output logic                         valid_out,
  input  logic                         hold,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int              AW         = $clog2(DEPTH);
  localparam int              CW         = $clog2(DEPTH+1);
  localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic          empty;
  logic          push;
  logic          pop;
  logic          bypass;
  logic [63:0]   head;

  assign empty     = (count == '0);
  assign ready_out = (count != FULL_COUNT);
  assign head      = mem[rp];

`ifdef FETCH_QUEUE_BYPASS_EN
  // An incoming word on an empty queue is forwarded; it only enters storage if held.
  assign bypass    = empty && valid_in && !flush;
  assign valid_out = (!empty || valid_in) && !flush;
  assign pop       = !empty && !flush && !hold;
  assign push      = valid_in && ready_out && !flush && !(bypass && !hold);
`else
  assign bypass    = 1'b0;
  assign valid_out = !empty && !flush;
  assign pop       = valid_out && !hold;
  assign push      = valid_in && ready_out && !flush;
`endif

  always_comb begin
    PC_out          = 32'h0;
    instruction_out = NOP;
    if (bypass) begin
      PC_out          = PC_in;
      instruction_out = instruction_in;
    end else if (valid_out) begin
      PC_out          = head[63:32];
      instruction_out = head[31:0];
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else if (flush) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only visible through valid_out.
  always_ff @(posedge Clock) begin
    if (push) mem[wp] <= {PC_in, instruction_in};
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : scoreboard bench for fetch_queue (DEPTH = 4).
// Revision 1.0
// ============================================================================
module tb_fetch_queue;

  logic        Clock = 1'b0;
  logic        nReset;
  logic [31:0] PC_in;
  logic [31:0] instruction_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] PC_out;
  logic [31:0] instruction_out;
  logic        valid_out;
  logic        hold;
  logic        flush;
  logic [2:0]  count;

  int          compared   = 0;
  int          mismatched = 0;
  logic [63:0] sb [$];
  logic [63:0] mon_exp;

  fetch_queue #(.DEPTH(4), .NOP(32'h0000_0013)) dut (
    .Clock           (Clock),
    .nReset          (nReset),
    .PC_in           (PC_in),
    .instruction_in  (instruction_in),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .PC_out          (PC_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out),
    .hold            (hold),
    .flush           (flush),
    .count           (count)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ pc;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic h,
                       input logic f, input logic acc);
    valid_in       = v;
    PC_in          = pc;
    instruction_in = ins(pc);
    hold           = h;
    flush          = f;
    if (acc) sb.push_back({pc, ins(pc)});
    step();
  endtask

  // Monitor: a head consumed at the coming edge must match the scoreboard front.
  always @(negedge Clock) begin
    if (nReset && valid_out && !hold && !flush) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL pop_unexpected: got PC %h, required no output", PC_out);
      end else begin
        mon_exp = sb.pop_front();
        chk("pop_pc", PC_out, mon_exp[63:32]);
        chk("pop_instr", instruction_out, mon_exp[31:0]);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0; valid_in = 1'b0; PC_in = '0; instruction_in = '0;
    hold = 1'b0; flush = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_ready", 32'(ready_out), 32'd1);
    chk("rst_instr", instruction_out, 32'h0000_0013);
    chk("rst_pc", PC_out, 32'h0);
    step();
    nReset = 1'b1;

    // Asynchronous reset with three entries queued
    drive(1, 32'h100, 1, 0, 1);
    drive(1, 32'h104, 1, 0, 1);
    drive(1, 32'h108, 1, 0, 1);
    chk("pre_rst_count", 32'(count), 32'd3);
    valid_in = 1'b0;
    #2;
    nReset = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_valid", 32'(valid_out), 32'd0);
    chk("arst_ready", 32'(ready_out), 32'd1);
    chk("arst_instr", instruction_out, 32'h0000_0013);
    chk("arst_pc", PC_out, 32'h0);
    sb.delete();
    step();
    nReset = 1'b1;
    hold   = 1'b0;

    // Streaming without hold
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i * 4), 0, 0, 1);
      chk("stream_count_le1", 32'(count <= 3'd1), 32'd1);
    end
    drive(0, 32'h0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
    chk("stream_drained", 32'(count), 32'd0);

    // Fill under hold, fifth word refused
    for (int i = 0; i < 4; i++) drive(1, 32'(i * 4), 1, 0, 1);
    chk("fill_count", 32'(count), 32'd4);
    chk("fill_ready", 32'(ready_out), 32'd0);
    drive(1, 32'h10, 1, 0, 0);
    chk("fill_5th_count", 32'(count), 32'd4);
    valid_in = 1'b0;
    hold     = 1'b0;
    #1;
    chk("ready_no_pop_dep", 32'(ready_out), 32'd0);
    step();
    chk("ready_after_pop", 32'(ready_out), 32'd1);
    chk("count_after_pop", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) drive(0, 32'h0, 0, 0, 0);
    chk("fill_drained", 32'(count), 32'd0);

    // Wrap-around at constant occupancy of two
    drive(1, 32'h200, 1, 0, 1);
    drive(1, 32'h204, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h208 + 32'(i * 4), 0, 0, 1);
      chk("wrap_count", 32'(count), 32'd2);
    end
    drive(0, 32'h0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
    chk("wrap_drained", 32'(count), 32'd0);

    // Flush with a concurrent push
    drive(1, 32'h300, 1, 0, 1);
    drive(1, 32'h304, 1, 0, 1);
    drive(1, 32'h308, 1, 0, 1);
    valid_in = 1'b1; PC_in = 32'h40; instruction_in = ins(32'h40);
    hold = 1'b0; flush = 1'b1;
    #1;
    chk("flush_valid_same", 32'(valid_out), 32'd0);
    chk("flush_pc_same", PC_out, 32'h0);
    chk("flush_instr_same", instruction_out, 32'h0000_0013);
    sb.delete();
    step();
    flush = 1'b0; valid_in = 1'b0;
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid_after", 32'(valid_out), 32'd0);
    drive(1, 32'h80, 1, 0, 1);
    chk("post_flush_head_pc", PC_out, 32'h80);
    chk("post_flush_valid", 32'(valid_out), 32'd1);
    chk("post_flush_count", 32'(count), 32'd1);
    drive(0, 32'h0, 0, 0, 0);
    chk("post_flush_drained", 32'(count), 32'd0);

    // Hold and flush together
    drive(1, 32'h500, 1, 0, 1);
    drive(1, 32'h504, 1, 0, 1);
    sb.delete();
    drive(0, 32'h0, 1, 1, 0);
    chk("hf_count", 32'(count), 32'd0);
    chk("hf_valid", 32'(valid_out), 32'd0);
    drive(0, 32'h0, 0, 0, 0);
    drive(0, 32'h0, 0, 0, 0);
    chk("hf_count_idle", 32'(count), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
